// File: rtl/ldm_stm_sequencer.sv
// Multi-cycle sequencer for ARM LDM/STM: one register<->memory transfer per accepted
// memory cycle in ascending register order, followed by an optional base writeback.
module ldm_stm_sequencer #(
  parameter int unsigned WordBytes = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] base_data_i,
  input  logic        mem_ready_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic [3:0]  reg_addr_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic        wb_sel_o,
  output logic [31:0] wb_data_o,
  output logic        pc_write_o,
  output logic        done_o
);

  typedef enum logic [1:0] {StIdle, StXfer, StWb, StDone} state_e;

  state_e      state_q;
  logic [15:0] list_q;
  logic [31:0] addr_q;
  logic [31:0] wb_data_q;
  logic [3:0]  rn_q;
  logic        load_q;
  logic        wb_en_q;

  logic        in_p, in_u, in_w, in_l;
  logic [3:0]  in_rn;
  logic [15:0] in_list;
  logic [4:0]  in_cnt;
  logic [31:0] span;
  logic [31:0] start_addr;
  logic [31:0] wb_value;
  logic        wb_allowed;
  logic [3:0]  cur_reg;
  logic [15:0] list_rest;
  logic        last_xfer;
  logic        unused_instr;

  assign in_p    = instr_i[24];
  assign in_u    = instr_i[23];
  assign in_w    = instr_i[21];
  assign in_l    = instr_i[20];
  assign in_rn   = instr_i[19:16];
  assign in_list = instr_i[15:0];

  assign unused_instr = ^{instr_i[31:25], instr_i[22]};

  always_comb begin
    in_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      in_cnt = in_cnt + 5'(in_list[i]);
    end
  end

  assign span = 32'(in_cnt) * 32'(WordBytes);

  // Lowest transfer address; registers always map upwards from it.
  always_comb begin
    start_addr = base_data_i;
    unique case ({in_p, in_u})
      2'b01:   start_addr = base_data_i;
      2'b11:   start_addr = base_data_i + 32'(WordBytes);
      2'b00:   start_addr = base_data_i - span + 32'(WordBytes);
      2'b10:   start_addr = base_data_i - span;
      default: start_addr = base_data_i;
    endcase
  end

  assign wb_value = in_u ? (base_data_i + span) : (base_data_i - span);

  // A load that reloads the base wins over the writeback.
  assign wb_allowed = in_w & ~(in_l & in_list[in_rn]);

  always_comb begin
    cur_reg = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) cur_reg = 4'(i);
    end
  end

  assign list_rest = list_q & (list_q - 16'd1);
  assign last_xfer = (list_rest == 16'd0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      list_q    <= '0;
      addr_q    <= '0;
      wb_data_q <= '0;
      rn_q      <= '0;
      load_q    <= 1'b0;
      wb_en_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            list_q    <= in_list;
            addr_q    <= start_addr;
            wb_data_q <= wb_value;
            rn_q      <= in_rn;
            load_q    <= in_l;
            wb_en_q   <= wb_allowed;
            state_q   <= (in_cnt != 5'd0) ? StXfer : StDone;
          end
        end
        StXfer: begin
          if (mem_ready_i) begin
            list_q <= list_rest;
            addr_q <= addr_q + 32'(WordBytes);
            if (last_xfer) state_q <= wb_en_q ? StWb : StDone;
          end
        end
        StWb:    state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  logic in_xfer;
  logic in_wb;
  assign in_xfer = (state_q == StXfer);
  assign in_wb   = (state_q == StWb);

  assign busy_o      = in_xfer | in_wb;
  assign stall_o     = (start_i & (state_q == StIdle)) | busy_o;
  assign done_o      = (state_q == StDone);
  assign reg_addr_o  = in_xfer ? cur_reg : (in_wb ? rn_q : 4'd0);
  assign mem_addr_o  = in_xfer ? addr_q : 32'd0;
  assign mem_write_o = in_xfer & ~load_q;
  assign reg_write_o = (in_xfer & load_q & mem_ready_i) | in_wb;
  assign wb_sel_o    = in_wb;
  assign wb_data_o   = wb_data_q;
  assign pc_write_o  = in_xfer & load_q & mem_ready_i & (cur_reg == 4'd15);

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: directed and random block transfers checked cycle by cycle
// against a transfer-list model built from the addressing-mode rules.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] instr;
  logic [31:0] base_data;
  logic        mem_ready;
  logic        busy, stall, mem_write, reg_write, wb_sel, pc_write, done;
  logic [3:0]  reg_addr;
  logic [31:0] mem_addr, wb_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ldm_stm_sequencer #(.WordBytes(4)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .instr_i    (instr),
    .base_data_i(base_data),
    .mem_ready_i(mem_ready),
    .busy_o     (busy),
    .stall_o    (stall),
    .reg_addr_o (reg_addr),
    .mem_addr_o (mem_addr),
    .mem_write_o(mem_write),
    .reg_write_o(reg_write),
    .wb_sel_o   (wb_sel),
    .wb_data_o  (wb_data),
    .pc_write_o (pc_write),
    .done_o     (done)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic p, input logic u, input logic w, input logic l,
                                     input logic [3:0] rn, input logic [15:0] lst);
    return {4'hE, 3'b100, p, u, 1'b0, w, l, rn, lst};
  endfunction

  task automatic chk_quiet(input string tag);
    chk1({tag, ".busy"}, busy, 1'b0);
    chk1({tag, ".done"}, done, 1'b0);
    chk1({tag, ".mem_write"}, mem_write, 1'b0);
    chk1({tag, ".reg_write"}, reg_write, 1'b0);
    chk1({tag, ".pc_write"}, pc_write, 1'b0);
    chk1({tag, ".wb_sel"}, wb_sel, 1'b0);
  endtask

  // mode 0: memory always ready; 1: random waits; 2: three wait cycles at XFER entry
  task automatic run_txn(input string tag, input logic [31:0] ins, input logic [31:0] base,
                         input int mode);
    logic        p, u, w, l, mr, do_wb;
    logic [3:0]  rn;
    logic [15:0] lst;
    logic [31:0] n, low, wbexp;
    int          regs[$];
    int          xc, waited;
    p = ins[24]; u = ins[23]; w = ins[21]; l = ins[20]; rn = ins[19:16]; lst = ins[15:0];
    n = 32'($countones(lst));
    if (p && u)       low = base + 32'd4;
    else if (u)       low = base;
    else if (p)       low = base - 4 * n;
    else              low = base - 4 * n + 32'd4;
    wbexp = u ? base + 4 * n : base - 4 * n;
    do_wb = w && (n != 0) && !(l && lst[rn]);
    regs = {};
    for (int r = 0; r < 16; r++) if (lst[r]) regs.push_back(r);

    start = 1'b1; instr = ins; base_data = base; mem_ready = 1'($urandom);
    #1;
    chk1({tag, ".accept_stall"}, stall, 1'b1);
    chk1({tag, ".accept_busy"}, busy, 1'b0);
    step();

    xc = 0;
    for (int k = 0; k < regs.size(); k++) begin
      waited = 0;
      while (1) begin
        if (mode == 0)      mr = 1'b1;
        else if (mode == 2) mr = (xc >= 3);
        else                mr = ($urandom_range(0, 2) != 0);
        if (waited >= 5) mr = 1'b1;
        mem_ready = mr;
        start = 1'($urandom_range(0, 1)); instr = $urandom; base_data = $urandom;
        #1;
        chk1({tag, ".x_busy"}, busy, 1'b1);
        chk1({tag, ".x_stall"}, stall, 1'b1);
        chk1({tag, ".x_done"}, done, 1'b0);
        chk32({tag, ".x_reg"}, 32'(reg_addr), 32'(regs[k]));
        chk32({tag, ".x_addr"}, mem_addr, low + 32'(4 * k));
        chk1({tag, ".x_mem_write"}, mem_write, !l);
        chk1({tag, ".x_reg_write"}, reg_write, l && mr);
        chk1({tag, ".x_pc_write"}, pc_write, l && mr && (regs[k] == 15));
        chk1({tag, ".x_wb_sel"}, wb_sel, 1'b0);
        step();
        xc++; waited++;
        if (mr) break;
      end
    end

    if (do_wb) begin
      mem_ready = 1'($urandom); start = 1'($urandom); instr = $urandom;
      #1;
      chk1({tag, ".wb_busy"}, busy, 1'b1);
      chk1({tag, ".wb_reg_write"}, reg_write, 1'b1);
      chk1({tag, ".wb_sel"}, wb_sel, 1'b1);
      chk1({tag, ".wb_mem_write"}, mem_write, 1'b0);
      chk32({tag, ".wb_reg"}, 32'(reg_addr), 32'(rn));
      chk32({tag, ".wb_data"}, wb_data, wbexp);
      step();
    end

    mem_ready = 1'($urandom); start = 1'($urandom); instr = $urandom;
    #1;
    chk1({tag, ".done"}, done, 1'b1);
    chk1({tag, ".done_busy"}, busy, 1'b0);
    chk1({tag, ".done_stall"}, stall, 1'b0);
    chk1({tag, ".done_reg_write"}, reg_write, 1'b0);
    chk1({tag, ".done_mem_write"}, mem_write, 1'b0);
    chk32({tag, ".done_wb_data"}, wb_data, wbexp);
    step();
    start = 1'b0;
    #1;
    chk_quiet({tag, ".idle"});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instr = '0; base_data = '0; mem_ready = 1'b1;
    #1;
    chk_quiet("rst");
    chk1("rst.stall", stall, 1'b0);
    chk32("rst.mem_addr", mem_addr, 32'd0);
    chk32("rst.wb_data", wb_data, 32'd0);
    chk32("rst.reg_addr", 32'(reg_addr), 32'd0);
    step(); step();
    reset = 1'b0;

    run_txn("ldmia_wb", mk(0, 1, 1, 1, 4'd0, 16'h0026), 32'h100, 0);
    run_txn("stmdb_wb", mk(1, 0, 1, 0, 4'd13, 16'h4010), 32'h1000, 0);
    run_txn("ldmda", mk(0, 0, 0, 1, 4'd3, 16'h0003), 32'h20, 0);
    run_txn("stmib_wait", mk(1, 1, 0, 0, 4'd2, 16'h0080), 32'h100, 2);
    run_txn("ldm_pc", mk(0, 1, 1, 1, 4'd1, 16'h8002), 32'h200, 0);
    run_txn("empty", mk(0, 1, 1, 1, 4'd4, 16'h0000), 32'h300, 0);
    run_txn("stm_rn_in", mk(0, 1, 1, 0, 4'd5, 16'h0021), 32'h400, 1);

    // Reset in the middle of a four-register load.
    start = 1'b1; instr = mk(0, 1, 1, 1, 4'd0, 16'h001E); base_data = 32'h800; mem_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    chk1("mid.busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk_quiet("mid_rst");
    chk32("mid_rst.mem_addr", mem_addr, 32'd0);
    chk32("mid_rst.wb_data", wb_data, 32'd0);
    chk32("mid_rst.reg_addr", 32'(reg_addr), 32'd0);
    step();
    reset = 1'b0;
    run_txn("after_rst", mk(1, 1, 1, 1, 4'd9, 16'h0C01), 32'h1234_5670, 1);

    for (int t = 0; t < 40; t++) begin
      logic [15:0] lst;
      lst = 16'($urandom);
      if (t % 5 == 0) lst = lst & 16'($urandom);
      if (t % 13 == 0) lst = '0;
      run_txn("rand", {$urandom_range(0, 127) == 0 ? 16'h0 : 16'($urandom >> 16) & 16'hFFFF,
                       lst} & 32'hFFFF_FFFF | 32'(lst),
              $urandom, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
